// File: rtl/complex_coeff_receiver_pkg.sv
// Shared definitions for the matched-filter coefficient path: the receiver's state
// encoding and the default coefficient geometry.
package complex_coeff_receiver_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_LENGTH     = 10000;
    localparam int DEFAULT_ADDR_WIDTH = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/complex_coeff_ram.sv
// Simple dual-port coefficient bank: one write port and one registered read port.
// When a read and a write hit the same address in one cycle, the read returns the old word.
module complex_coeff_ram #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 10000,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    // The non-blocking read picks up the previous contents on a same-address collision.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
        rd_data <= mem[rd_addr[IDX_W-1:0]];
    end

endmodule

// File: rtl/complex_coeff_receiver.sv
// Loads LENGTH complex coefficients from a valid-qualified stream into a bank, flags
// completion, and serves the taps to the complex FIR through a registered read port.
module complex_coeff_receiver
    import complex_coeff_receiver_pkg::*;
#(
    parameter int LENGTH     = DEFAULT_LENGTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         enable,
    input  logic                         reload,
    input  logic                         dataInValid,
    input  logic signed [DATA_WIDTH-1:0] dataInRe,
    input  logic signed [DATA_WIDTH-1:0] dataInIm,
    input  logic        [ADDR_WIDTH-1:0] readAddr,
    output logic signed [DATA_WIDTH-1:0] coeffOutRe,
    output logic signed [DATA_WIDTH-1:0] coeffOutIm,
    output logic                         coeffSetFlag,
    output logic        [ADDR_WIDTH-1:0] loadCount,
    output logic                         overrun
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(LENGTH - 1);
    localparam logic [ADDR_WIDTH-1:0] FULL_COUNT = ADDR_WIDTH'(LENGTH);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   load_count_q, load_count_d;
    logic                    coeff_set_q, coeff_set_d;
    logic                    overrun_q, overrun_d;
    logic                    rd_valid_q, rd_valid_d;

    logic                    wr_en;
    logic [2*DATA_WIDTH-1:0] wr_data;
    logic [2*DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    rd_in_range;

    always_comb begin
        state_d      = state_q;
        load_count_d = load_count_q;
        coeff_set_d  = coeff_set_q;
        overrun_d    = overrun_q;
        wr_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load_count_d = '0;
                coeff_set_d  = 1'b0;
                if (enable) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Dropping enable wins over a word arriving in the same cycle.
                if (!enable) begin
                    state_d      = ST_IDLE;
                    load_count_d = '0;
                end else if (dataInValid) begin
                    wr_en = 1'b1;
                    if (load_count_q == LAST_IDX) begin
                        state_d      = ST_DONE;
                        coeff_set_d  = 1'b1;
                        load_count_d = FULL_COUNT;
                    end else begin
                        load_count_d = load_count_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (reload) begin
                    state_d      = ST_IDLE;
                    load_count_d = '0;
                    coeff_set_d  = 1'b0;
                    overrun_d    = 1'b0;
                end else if (dataInValid) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                load_count_d = '0;
                coeff_set_d  = 1'b0;
            end
        endcase
    end

    // Out-of-range taps read address 0 and are masked to zero one cycle later.
    assign rd_in_range = (readAddr <= LAST_IDX);
    assign rd_addr     = rd_in_range ? readAddr : '0;
    assign rd_valid_d  = rd_in_range;
    assign wr_data     = {dataInRe, dataInIm};

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q      <= ST_IDLE;
            load_count_q <= '0;
            coeff_set_q  <= 1'b0;
            overrun_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_count_q <= load_count_d;
            coeff_set_q  <= coeff_set_d;
            overrun_q    <= overrun_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    complex_coeff_ram #(
        .WIDTH      (2 * DATA_WIDTH),
        .DEPTH      (LENGTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (load_count_q),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign coeffOutRe   = rd_valid_q ? rd_data[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign coeffOutIm   = rd_valid_q ? rd_data[DATA_WIDTH-1:0]            : '0;
    assign coeffSetFlag = coeff_set_q;
    assign loadCount    = load_count_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_complex_coeff_receiver.sv
// Directed bench for complex_coeff_receiver with an 8-entry bank and a 14-bit address.
module tb_complex_coeff_receiver;

    localparam int LENGTH     = 8;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 14;

    logic                         clock = 1'b0;
    logic                         resetN;
    logic                         enable;
    logic                         reload;
    logic                         dataInValid;
    logic signed [DATA_WIDTH-1:0] dataInRe;
    logic signed [DATA_WIDTH-1:0] dataInIm;
    logic        [ADDR_WIDTH-1:0] readAddr;
    logic signed [DATA_WIDTH-1:0] coeffOutRe;
    logic signed [DATA_WIDTH-1:0] coeffOutIm;
    logic                         coeffSetFlag;
    logic        [ADDR_WIDTH-1:0] loadCount;
    logic                         overrun;

    int vectors   = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    complex_coeff_receiver #(
        .LENGTH     (LENGTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clock        (clock),
        .resetN       (resetN),
        .enable       (enable),
        .reload       (reload),
        .dataInValid  (dataInValid),
        .dataInRe     (dataInRe),
        .dataInIm     (dataInIm),
        .readAddr     (readAddr),
        .coeffOutRe   (coeffOutRe),
        .coeffOutIm   (coeffOutIm),
        .coeffSetFlag (coeffSetFlag),
        .loadCount    (loadCount),
        .overrun      (overrun)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put_word(input int re, input int im);
        dataInValid = 1'b1;
        dataInRe    = 16'(re);
        dataInIm    = 16'(im);
        tick();
        dataInValid = 1'b0;
    endtask

    task automatic read_check(input string tag, input int addr, input int re, input int im);
        readAddr = 14'(addr);
        tick();
        check({tag, "_re"}, coeffOutRe, 16'(re));
        check({tag, "_im"}, coeffOutIm, 16'(im));
    endtask

    initial begin
        resetN      = 1'b0;
        enable      = 1'b0;
        reload      = 1'b0;
        dataInValid = 1'b0;
        dataInRe    = '0;
        dataInIm    = '0;
        readAddr    = '0;

        // Reset held for three cycles with stray valid pulses.
        for (int i = 0; i < 3; i++) begin
            dataInValid = (i != 1);
            dataInRe    = 16'(11 + i);
            tick();
        end
        dataInValid = 1'b0;
        check("rst_flag", 16'(coeffSetFlag), 16'd0);
        check("rst_count", 16'(loadCount), 16'd0);
        check("rst_overrun", 16'(overrun), 16'd0);
        check("rst_re", coeffOutRe, 16'd0);
        check("rst_im", coeffOutIm, 16'd0);

        // Enable with a simultaneous valid word: the word is ignored in IDLE.
        resetN      = 1'b1;
        enable      = 1'b1;
        dataInValid = 1'b1;
        dataInRe    = 16'd99;
        dataInIm    = 16'd99;
        tick();
        dataInValid = 1'b0;
        check("idle_word_ignored", 16'(loadCount), 16'd0);

        // Full load Re=k, Im=-k.
        for (int k = 0; k < LENGTH; k++) begin
            put_word(k, -k);
            check("load_count", 16'(loadCount), 16'(k + 1));
            check("load_flag", 16'(coeffSetFlag), (k == LENGTH - 1) ? 16'd1 : 16'd0);
        end
        check("load_overrun", 16'(overrun), 16'd0);
        read_check("read5", 5, 5, -5);

        // Overrun in DONE; enable has no effect there.
        put_word(77, 77);
        check("overrun_set", 16'(overrun), 16'd1);
        check("overrun_count", 16'(loadCount), 16'd8);
        enable = 1'b0;
        tick();
        check("done_ignores_enable", 16'(coeffSetFlag), 16'd1);
        check("overrun_sticky", 16'(overrun), 16'd1);
        enable = 1'b1;
        for (int k = 0; k < LENGTH; k++) begin
            read_check("bank_after_overrun", k, k, -k);
        end

        // Reload and a new bank Re=100+k.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("reload_flag", 16'(coeffSetFlag), 16'd0);
        check("reload_overrun", 16'(overrun), 16'd0);
        check("reload_count", 16'(loadCount), 16'd0);
        tick();
        for (int k = 0; k < LENGTH; k++) begin
            put_word(100 + k, -(100 + k));
        end
        check("reload_done_flag", 16'(coeffSetFlag), 16'd1);
        read_check("read3_reloaded", 3, 103, -103);

        // Gapped stream then abort after three words.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        tick();
        for (int j = 0; j < 3; j++) begin
            put_word(50 + j, 50 + j);
            tick();
            tick();
        end
        check("gap_count", 16'(loadCount), 16'd3);
        check("gap_flag", 16'(coeffSetFlag), 16'd0);
        enable      = 1'b0;
        dataInValid = 1'b1;
        dataInRe    = 16'd66;
        tick();
        dataInValid = 1'b0;
        check("abort_count", 16'(loadCount), 16'd0);
        check("abort_flag", 16'(coeffSetFlag), 16'd0);
        tick();
        check("abort_stays_idle", 16'(loadCount), 16'd0);

        // Restarted load completes.
        enable = 1'b1;
        tick();
        for (int k = 0; k < LENGTH; k++) begin
            put_word(20 + k, -(20 + k));
        end
        check("restart_flag", 16'(coeffSetFlag), 16'd1);
        check("restart_count", 16'(loadCount), 16'd8);
        read_check("restart_read7", 7, 27, -27);

        // Out-of-range reads.
        read_check("oor8", 8, 0, 0);
        read_check("restart_read1", 1, 21, -21);
        read_check("oor16383", 16383, 0, 0);

        // Same-cycle write and read of address 2.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        tick();
        put_word(40, -40);
        put_word(41, -41);
        readAddr = 14'd2;
        put_word(42, -42);
        check("rdw_old_re", coeffOutRe, 16'd22);
        check("rdw_old_im", coeffOutIm, 16'(-22));
        put_word(43, -43);
        check("rdw_new_re", coeffOutRe, 16'd42);
        check("rdw_new_im", coeffOutIm, 16'(-42));

        // Reset while word 4 is presented.
        resetN      = 1'b0;
        dataInValid = 1'b1;
        dataInRe    = 16'd44;
        tick();
        dataInValid = 1'b0;
        check("midrst_flag", 16'(coeffSetFlag), 16'd0);
        check("midrst_count", 16'(loadCount), 16'd0);
        check("midrst_re", coeffOutRe, 16'd0);
        resetN = 1'b1;
        enable = 1'b0;
        tick();
        check("post_rst_count", 16'(loadCount), 16'd0);
        check("post_rst_flag", 16'(coeffSetFlag), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/complex_coeff_receiver.md
# complex_coeff_receiver

Receiving end of the coefficient stream produced by the MIF reader in the matched-filter chain. It accepts LENGTH complex coefficients (real/imag pairs) on a valid-qualified stream and writes them into an internal coefficient bank. It raises coeffSetFlag once the bank is complete, then serves coefficients to the complex FIR through a registered read port. Between the MIF reader and the n-tap complex FIR, it replaces ad-hoc coefficient wiring with a checked load sequence.

## Interface
- LENGTH, 10000, number of complex coefficients per load.
- DATA_WIDTH, 16, signed width of each real/imag component.
- ADDR_WIDTH, 14, bank address width; must satisfy 2^ADDR_WIDTH >= LENGTH.

- clock  in  1  system clock, all logic on rising edge.
- resetN  in  1  synchronous, active-low reset.
- enable  in  1  load permission; high starts/continues a load, low aborts an unfinished load.
- reload  in  1  single-cycle request to discard a completed bank and accept a new load.
- dataInValid  in  1  coefficient present on dataInRe/dataInIm this cycle.
- dataInRe  in  DATA_WIDTH  signed real part.
- dataInIm  in  DATA_WIDTH  signed imaginary part.
- readAddr  in  ADDR_WIDTH  FIR tap index to read.
- coeffOutRe  out  DATA_WIDTH  signed real coefficient at the registered readAddr.
- coeffOutIm  out  DATA_WIDTH  signed imaginary coefficient at the registered readAddr.
- coeffSetFlag  out  1  bank holds a complete, valid set.
- loadCount  out  ADDR_WIDTH  number of coefficients written in the current load.
- overrun  out  1  sticky; a valid word arrived while the bank was complete.

## Operation
- States: IDLE, LOAD, DONE.
- **IDLE**
  - loadCount = 0 and coeffSetFlag = 0.
  - enable = 1 → LOAD on the next edge. A dataInValid on that same cycle is ignored.
- **LOAD**
  - Each cycle with dataInValid = 1 writes {dataInRe, dataInIm} to bank[loadCount] and increments loadCount.
  - On the write of index LENGTH-1: next state DONE, coeffSetFlag = 1 and loadCount = LENGTH, all on the same edge.
  - enable = 0 → IDLE and loadCount = 0 (abort); any write in that cycle is discarded. Bank contents are left undefined.
  - Gaps in dataInValid are allowed and have no timeout.
- **DONE**
  - coeffSetFlag stays high and further writes are blocked.
  - dataInValid = 1 sets overrun = 1 (sticky).
  - enable has no effect.
  - reload = 1 → IDLE, clearing coeffSetFlag, loadCount and overrun.
- reload is ignored in IDLE and LOAD.
- Read port
  - readAddr is sampled every cycle, independent of state.
  - readAddr >= LENGTH returns 0 on both components.
  - A read that hits the address being written in the same cycle returns the old contents.
- Reset
  - resetN = 0 on any edge forces IDLE, loadCount = 0, coeffSetFlag = 0, overrun = 0, coeffOutRe = 0 and coeffOutIm = 0.
  - Bank RAM is not cleared.
  - Reset in the middle of a load discards that load.
- Values are stored bit-exact, with no scaling or sign extension.

## Timing
- Write latency: a word presented with dataInValid at edge N is readable for readAddr presented at edge N+1 or later.
- Read latency: 1 cycle from readAddr to coeffOutRe/coeffOutIm. Outputs are registered.
- coeffSetFlag rises on the same edge that stores the final word.
- Minimum load time: LENGTH+1 cycles from enable rising in IDLE.
- Throughput: one coefficient per cycle, with no back-pressure.
  - The sender must not present words before coeffSetFlag-triggered or enable-triggered sequencing allows it.
  - Words outside LOAD are dropped; in DONE they are flagged through overrun.

## Structure
- Shared package/header holds:
  - state encodings (IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2);
  - the default DATA_WIDTH, LENGTH and ADDR_WIDTH constants used by the matched-filter blocks.
- Sub-module complex_coeff_ram: simple dual-port RAM with one write port and one registered read port, 2*DATA_WIDTH wide and LENGTH deep, written to infer block RAM.
- FSM, counter, overrun logic and the out-of-range read zeroing live in the top block.

## Test plan
- **Reset values:** resetN low for 3 cycles → all outputs 0 and state IDLE; dataInValid pulses are ignored.
- **Full load (LENGTH = 8):**
  - Stimulus: enable high, then 8 valid words with Re = k and Im = -k for k = 0..7.
  - coeffSetFlag rises on the edge storing k = 7, and loadCount = 8.
  - readAddr = 5 gives Re = 5 and Im = -5 one cycle later.
- **Gapped stream and abort:**
  - Valid words come every third cycle. enable drops after 3 words → IDLE, loadCount = 0, coeffSetFlag stays 0.
  - A restarted load of 8 words completes normally.
- **Overrun:** after DONE, one extra valid word → overrun = 1, bank unchanged (readAddr 0..7 still returns the original words).
- **Reload:** reload pulse in DONE → coeffSetFlag and overrun clear; a new load with Re = 100+k overwrites the bank, and readAddr = 3 returns 103.
- **Boundary reads:**
  - readAddr = 8 or 16383 → outputs 0.
  - Write and read of address 2 in the same cycle → old value returned, new value visible on the next read.
  - Reset asserted mid-load at word 4 → IDLE, flag 0.
